// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the VGA raster timing block.
//   - 640x480@60 timing defaults (25 MHz pixel clock)
//   - derived line/frame totals
//   - counter, coordinate and colour widths
//   - packed RGB triple type
//   - inclusive window compare helper used for the sync regions
// ----------------------------------------------------------------------------
package vga_pkg;

    // Horizontal timing in pixel clocks
    localparam int VGA_H_ACTIVE = 32'd640;
    localparam int VGA_H_FP     = 32'd16;
    localparam int VGA_H_SYNC   = 32'd96;
    localparam int VGA_H_BP     = 32'd48;

    // Vertical timing in lines
    localparam int VGA_V_ACTIVE = 32'd480;
    localparam int VGA_V_FP     = 32'd10;
    localparam int VGA_V_SYNC   = 32'd2;
    localparam int VGA_V_BP     = 32'd33;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Widths
    localparam int CNT_W = 32'd10;
    localparam int COL_W = 32'd10;
    localparam int ROW_W = 32'd9;
    localparam int RGB_W = 32'd4;

    // One pixel's colour as it travels to the pins
    typedef struct packed {
        logic [RGB_W-1:0] r;
        logic [RGB_W-1:0] g;
        logic [RGB_W-1:0] b;
    } rgb_t;

    // True when value lies in the inclusive range [lo, hi]
    function automatic logic in_window(input logic [CNT_W-1:0] value,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_timing_if.sv
// ----------------------------------------------------------------------------
// vga_sync_timing_if
// Pixel-colour interface between the raster timing block and the colour
// generator.
//   col, row      : current visible coordinate (0 outside the active region)
//   video_on      : current coordinate is visible
//   frame_start   : high for the single pixel (0,0) of each frame
//   red_in/green_in/blue_in : generator colour for the current coordinate
// master = timing side, slave = colour generator side.
// ----------------------------------------------------------------------------
interface vga_sync_timing_if;
    import vga_pkg::*;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             video_on;
    logic             frame_start;
    logic [RGB_W-1:0] red_in;
    logic [RGB_W-1:0] green_in;
    logic [RGB_W-1:0] blue_in;

    modport master (
        output col,
        output row,
        output video_on,
        output frame_start,
        input  red_in,
        input  green_in,
        input  blue_in
    );

    modport slave (
        input  col,
        input  row,
        input  video_on,
        input  frame_start,
        output red_in,
        output green_in,
        output blue_in
    );

endinterface

// File: rtl/vga_axis_counter.sv
// ----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis: counts 0 .. ACTIVE+FP+SYNC+BP-1 and wraps.
//   clk, rst_n : pixel clock, asynchronous active-low reset
//   enable     : advance by one on this clock
//   count      : current position on the axis
//   active     : count is inside the visible region
//   sync_raw   : sync level for the current count (SYNC_ACTIVE inside the
//                sync pulse, its inverse elsewhere)
//   wrap       : this clock advances the counter from its last value to 0
// ----------------------------------------------------------------------------
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int   ACTIVE      = VGA_H_ACTIVE,
    parameter int   FP          = VGA_H_FP,
    parameter int   SYNC        = VGA_H_SYNC,
    parameter int   BP          = VGA_H_BP,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             active,
    output logic             sync_raw,
    output logic             wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(TOTAL - 32'd1);
    localparam logic [CNT_W-1:0] ACTIVE_C  = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_LO_C = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_HI_C = CNT_W'(ACTIVE + FP + SYNC - 32'd1);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             at_last_s;

    assign at_last_s = (count_r == LAST_C);

    // Next position: hold unless enabled, wrap to zero after the last position
    always_comb begin
        count_nxt_s = count_r;
        if (enable) begin
            if (at_last_s) begin
                count_nxt_s = {CNT_W{1'b0}};
            end else begin
                count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Position register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign count    = count_r;
    assign active   = (count_r < ACTIVE_C);
    assign sync_raw = in_window(count_r, SYNC_LO_C, SYNC_HI_C) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign wrap     = enable && at_last_s;

endmodule

// File: rtl/vga_sync_timing.sv
// ----------------------------------------------------------------------------
// vga_sync_timing
// Owns the VGA raster. Publishes the current coordinate to the colour
// generator over the pixel interface, takes its colour back and registers
// colour and sync together into the pin stage.
//   vga_clk     : pixel clock (25 MHz for 640x480@60), the only clock
//   rst_n       : asynchronous active-low reset
//   pix         : pixel-colour interface (col, row, video_on, frame_start out;
//                 red_in, green_in, blue_in in)
//   vga_r/g/b   : registered colour to pins, zero outside the visible region
//   vga_hs/vs   : registered sync to pins
// Pin outputs lag col/row by exactly one clock; colour and sync share that lag
// so they stay aligned at the connector.
// ----------------------------------------------------------------------------
module vga_sync_timing
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE    = VGA_H_ACTIVE,
    parameter int   H_FP        = VGA_H_FP,
    parameter int   H_SYNC      = VGA_H_SYNC,
    parameter int   H_BP        = VGA_H_BP,
    parameter int   V_ACTIVE    = VGA_V_ACTIVE,
    parameter int   V_FP        = VGA_V_FP,
    parameter int   V_SYNC      = VGA_V_SYNC,
    parameter int   V_BP        = VGA_V_BP,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic              vga_clk,
    input  logic              rst_n,
    vga_sync_timing_if.master pix,
    output logic [RGB_W-1:0]  vga_r,
    output logic [RGB_W-1:0]  vga_g,
    output logic [RGB_W-1:0]  vga_b,
    output logic              vga_hs,
    output logic              vga_vs
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] V_ACTIVE_C = CNT_W'(V_ACTIVE);

    // The counters are 10 bits wide and row is 9 bits wide
    if ((H_TOTAL > 32'd1024) || (V_TOTAL > 32'd1024) || (V_ACTIVE > 32'd512)) begin : g_bad_timing
        $error("vga_sync_timing: timing parameters exceed counter or row width");
    end

    logic [CNT_W-1:0] h_cnt_s;
    logic [CNT_W-1:0] v_cnt_s;
    logic             h_active_s;
    logic             v_active_s;
    logic             hsync_raw_s;
    logic             vsync_raw_s;
    logic             h_wrap_s;
    logic             v_wrap_s;
    logic             video_on_s;
    rgb_t             pix_rgb_s;
    rgb_t             pin_rgb_r;
    logic             vga_hs_r;
    logic             vga_vs_r;
    logic             frame_start_r;

    vga_axis_counter #(
        .ACTIVE      (H_ACTIVE),
        .FP          (H_FP),
        .SYNC        (H_SYNC),
        .BP          (H_BP),
        .SYNC_ACTIVE (SYNC_ACTIVE)
    ) u_h_axis (
        .clk      (vga_clk),
        .rst_n    (rst_n),
        .enable   (1'b1),
        .count    (h_cnt_s),
        .active   (h_active_s),
        .sync_raw (hsync_raw_s),
        .wrap     (h_wrap_s)
    );

    // Lines advance on the last pixel of each line, so both axes wrap together
    vga_axis_counter #(
        .ACTIVE      (V_ACTIVE),
        .FP          (V_FP),
        .SYNC        (V_SYNC),
        .BP          (V_BP),
        .SYNC_ACTIVE (SYNC_ACTIVE)
    ) u_v_axis (
        .clk      (vga_clk),
        .rst_n    (rst_n),
        .enable   (h_wrap_s),
        .count    (v_cnt_s),
        .active   (v_active_s),
        .sync_raw (vsync_raw_s),
        .wrap     (v_wrap_s)
    );

    assign video_on_s = h_active_s && v_active_s;

    // Coordinates read as 0 in blanking; row compares the full count so a
    // line number above V_ACTIVE can never alias into the 9-bit row.
    assign pix.col      = h_active_s ? h_cnt_s[COL_W-1:0] : {COL_W{1'b0}};
    assign pix.row      = (v_cnt_s < V_ACTIVE_C) ? v_cnt_s[ROW_W-1:0] : {ROW_W{1'b0}};
    assign pix.video_on = video_on_s;

    assign pix_rgb_s.r = pix.red_in;
    assign pix_rgb_s.g = pix.green_in;
    assign pix_rgb_s.b = pix.blue_in;

    // frame_start: set by the edge that wraps both axes, i.e. high exactly
    // while the raster sits at (0,0); reset also lands on (0,0).
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start_r <= 1'b1;
        end else begin
            frame_start_r <= v_wrap_s;
        end
    end

    assign pix.frame_start = frame_start_r;

    // Pin stage: one clock of latency for colour and sync alike, colour blanked
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_rgb_r <= {(3*RGB_W){1'b0}};
            vga_hs_r  <= ~SYNC_ACTIVE;
            vga_vs_r  <= ~SYNC_ACTIVE;
        end else begin
            if (video_on_s) begin
                pin_rgb_r <= pix_rgb_s;
            end else begin
                pin_rgb_r <= {(3*RGB_W){1'b0}};
            end
            vga_hs_r <= hsync_raw_s;
            vga_vs_r <= vsync_raw_s;
        end
    end

    assign vga_r  = pin_rgb_r.r;
    assign vga_g  = pin_rgb_r.g;
    assign vga_b  = pin_rgb_r.b;
    assign vga_hs = vga_hs_r;
    assign vga_vs = vga_vs_r;

endmodule
